// File: rtl/dsp_preadd_checker_pkg.sv
// Shared types and helpers for the pre-adder multiplier checkers (package dsp_chk_pkg).
// Record lengths cover both builds, with and without DSP_CHK_LAST_ERR_EN.
package dsp_chk_pkg;

    localparam int EXT_MAXW = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } rd_state_t;

    function automatic int rec_len(input int cntw, input int zw, input logic last_en);
        return 2 * cntw + (last_en ? 4 * zw : 2 * zw);
    endfunction

    localparam int REC_LEN_BASE = rec_len(16, 36, 1'b0);
    localparam int REC_LEN_LAST = rec_len(16, 36, 1'b1);

    // Extends the low 'width' bits of value: fills upper bits with the MSB when signed_flag is set.
    function automatic logic [EXT_MAXW-1:0] ext(input logic [EXT_MAXW-1:0] value,
                                                input logic signed_flag,
                                                input int width);
        logic [EXT_MAXW-1:0] mask;
        logic fill;
        mask = {EXT_MAXW{1'b1}} << width;
        fill = signed_flag & (|(value & ~mask & (mask >> 1)));
        return fill ? (value | mask) : (value & ~mask);
    endfunction

endpackage

// File: rtl/dsp_preadd_model.sv
// Golden model of a pre-adder multiplier: registered C, combinational A/B,
// z_exp = a * (b + c_model), truncated to ZW bits.
module dsp_preadd_model
    import dsp_chk_pkg::*;
#(
    parameter int AW = 18,
    parameter int ZW = 36
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          strobe,
    input  logic          rstc,
    input  logic          cec,
    input  logic          a_signed,
    input  logic          b_signed,
    input  logic          c_signed,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [AW-1:0] c,
    output logic [ZW-1:0] z_exp
);

    logic [AW-1:0] c_model;
    logic [AW+1:0] b_ext;
    logic [AW+1:0] c_ext;
    logic [AW+1:0] sum;
    logic [ZW+1:0] a_wide;
    logic [ZW+1:0] sum_wide;

    // Reset of the C register wins over its enable, both only on strobe cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_model <= '0;
        end else if (strobe && rstc) begin
            c_model <= '0;
        end else if (strobe && cec) begin
            c_model <= c;
        end
    end

    always_comb begin
        b_ext    = (AW+2)'(ext(EXT_MAXW'(b), b_signed, AW));
        c_ext    = (AW+2)'(ext(EXT_MAXW'(c_model), c_signed, AW));
        sum      = b_ext + c_ext;
        a_wide   = (ZW+2)'(ext(EXT_MAXW'(a), a_signed, AW));
        sum_wide = (ZW+2)'(ext(EXT_MAXW'(sum), b_signed | c_signed, AW + 2));
        z_exp    = ZW'(a_wide * sum_wide);
    end

endmodule

// File: rtl/dsp_preadd_checker.sv
// Checks a pre-adder multiplier DUT's Z on every strobe, counts mismatches and streams a result record.
// Defining DSP_CHK_LAST_ERR_EN also records the most recent mismatch in the readout.
module dsp_preadd_checker
    import dsp_chk_pkg::*;
#(
    parameter int AW   = 18,
    parameter int ZW   = 36,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            strobe,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic            c_signed,
    input  logic [AW-1:0]   a,
    input  logic [AW-1:0]   b,
    input  logic [AW-1:0]   c,
    input  logic            rstc,
    input  logic            cec,
    input  logic [ZW-1:0]   z_dut,
    input  logic            rd_req,
    output logic            rd_bit,
    output logic            rd_valid,
    output logic            rd_last,
    output logic [CNTW-1:0] err_count,
    output logic            err_seen,
    output logic            busy
);

`ifdef DSP_CHK_LAST_ERR_EN
    localparam int REC_LEN = rec_len(CNTW, ZW, 1'b1);
`else
    localparam int REC_LEN = rec_len(CNTW, ZW, 1'b0);
`endif
    localparam int LW = $clog2(REC_LEN);

    logic [ZW-1:0]      z_exp;
    logic               mism_r;
    logic [ZW-1:0]      exp_r;
    logic [ZW-1:0]      got_r;
    logic [CNTW-1:0]    idx_r;
    logic [CNTW-1:0]    strobe_idx;
    logic [CNTW-1:0]    first_idx;
    logic [ZW-1:0]      first_exp;
    logic [ZW-1:0]      first_got;
    logic [REC_LEN-1:0] record;
    logic [REC_LEN-1:0] shreg;
    logic [LW-1:0]      bits_left;
    rd_state_t          state;

    dsp_preadd_model #(
        .AW(AW),
        .ZW(ZW)
    ) u_model (
        .clk      (clk),
        .resetn   (resetn),
        .strobe   (strobe),
        .rstc     (rstc),
        .cec      (cec),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .c_signed (c_signed),
        .a        (a),
        .b        (b),
        .c        (c),
        .z_exp    (z_exp)
    );

    // The compare is registered so a mismatch lands on the counters one edge after its strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mism_r     <= 1'b0;
            exp_r      <= '0;
            got_r      <= '0;
            idx_r      <= '0;
            strobe_idx <= '0;
        end else if (strobe) begin
            mism_r     <= (z_dut != z_exp);
            exp_r      <= z_exp;
            got_r      <= z_dut;
            idx_r      <= strobe_idx;
            strobe_idx <= strobe_idx + 1'b1;
        end else begin
            mism_r     <= 1'b0;
        end
    end

`ifdef DSP_CHK_LAST_ERR_EN
    logic [ZW-1:0] last_exp;
    logic [ZW-1:0] last_got;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_exp <= '0;
            last_got <= '0;
        end else if (mism_r) begin
            last_exp <= exp_r;
            last_got <= got_r;
        end
    end

    assign record = {err_count, first_idx, first_exp, first_got, last_exp, last_got};
`else
    assign record = {err_count, first_idx, first_exp, first_got};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= '0;
            err_seen  <= 1'b0;
            first_idx <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else if (mism_r) begin
            if (err_count != {CNTW{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
            err_seen <= 1'b1;
            if (!err_seen) begin
                first_idx <= idx_r;
                first_exp <= exp_r;
                first_got <= got_r;
            end
        end
    end

    // Readout: LOAD snapshots the record, SHIFT emits it MSB first with bits_left counting down.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            shreg     <= '0;
            bits_left <= '0;
            rd_bit    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg     <= {record[REC_LEN-2:0], 1'b0};
                    rd_bit    <= record[REC_LEN-1];
                    rd_valid  <= 1'b1;
                    rd_last   <= 1'b0;
                    bits_left <= LW'(REC_LEN - 1);
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (bits_left == '0) begin
                        state    <= IDLE;
                        rd_bit   <= 1'b0;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        shreg     <= {shreg[REC_LEN-2:0], 1'b0};
                        rd_bit    <= shreg[REC_LEN-1];
                        rd_last   <= (bits_left == LW'(1));
                        bits_left <= bits_left - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_preadd_checker.sv
// Scoreboard bench for dsp_preadd_checker: random and directed strobes against an arithmetic reference;
// also covers the DSP_CHK_LAST_ERR_EN record layout when that macro is defined.
module tb_dsp_preadd_checker;

    localparam int AW   = 18;
    localparam int ZW   = 36;
    localparam int CNTW = 16;
`ifdef DSP_CHK_LAST_ERR_EN
    localparam int REC_LEN = 2 * CNTW + 4 * ZW;
`else
    localparam int REC_LEN = 2 * CNTW + 2 * ZW;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            strobe = 1'b0;
    logic            a_signed = 1'b0;
    logic            b_signed = 1'b0;
    logic            c_signed = 1'b0;
    logic [AW-1:0]   a = '0;
    logic [AW-1:0]   b = '0;
    logic [AW-1:0]   c = '0;
    logic            rstc = 1'b0;
    logic            cec = 1'b0;
    logic [ZW-1:0]   z_dut = '0;
    logic            rd_req = 1'b0;
    logic            rd_bit;
    logic            rd_valid;
    logic            rd_last;
    logic [CNTW-1:0] err_count;
    logic            err_seen;
    logic            busy;

    typedef struct {
        logic [CNTW-1:0] cnt;
        logic            seen;
    } err_exp_t;

    err_exp_t           err_q[$];
    logic [REC_LEN-1:0] rec_q[$];

    int checks = 0;
    int failures = 0;

    // Reference state, updated at the moment each strobe is issued
    logic [AW-1:0]   m_c;
    logic [CNTW-1:0] m_cnt;
    logic [CNTW-1:0] m_idx;
    logic [CNTW-1:0] m_fidx;
    logic            m_seen;
    logic [ZW-1:0]   m_fexp;
    logic [ZW-1:0]   m_fgot;
`ifdef DSP_CHK_LAST_ERR_EN
    logic [ZW-1:0]   m_lexp;
    logic [ZW-1:0]   m_lgot;
`endif

    logic               pend1 = 1'b0;
    logic               pend2 = 1'b0;
    logic [REC_LEN-1:0] col = '0;
    int                 ncol = 0;

    dsp_preadd_checker #(
        .AW(AW),
        .ZW(ZW),
        .CNTW(CNTW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .strobe    (strobe),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .c_signed  (c_signed),
        .a         (a),
        .b         (b),
        .c         (c),
        .rstc      (rstc),
        .cec       (cec),
        .z_dut     (z_dut),
        .rd_req    (rd_req),
        .rd_bit    (rd_bit),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .err_count (err_count),
        .err_seen  (err_seen),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Plain integer arithmetic: a * (b + c), each operand read as signed or unsigned, mod 2^ZW
    function automatic logic [ZW-1:0] golden(input logic [AW-1:0] ga, input logic [AW-1:0] gb,
                                             input logic [AW-1:0] gc, input logic sa,
                                             input logic sb, input logic sc);
        longint va, vb, vc;
        logic [63:0] p;
        va = sa ? longint'($signed(ga)) : longint'(ga);
        vb = sb ? longint'($signed(gb)) : longint'(gb);
        vc = sc ? longint'($signed(gc)) : longint'(gc);
        p = 64'(va * (vb + vc));
        return p[ZW-1:0];
    endfunction

    function automatic logic [REC_LEN-1:0] expRecord();
`ifdef DSP_CHK_LAST_ERR_EN
        return {m_cnt, m_fidx, m_fexp, m_fgot, m_lexp, m_lgot};
`else
        return {m_cnt, m_fidx, m_fexp, m_fgot};
`endif
    endfunction

    function automatic void clearModel();
        m_c = '0; m_cnt = '0; m_idx = '0; m_fidx = '0; m_seen = 1'b0;
        m_fexp = '0; m_fgot = '0;
`ifdef DSP_CHK_LAST_ERR_EN
        m_lexp = '0; m_lgot = '0;
`endif
    endfunction

    // zmode: 0 = matching z_dut, 1 = one bit flipped, 2 = explicit z_val
    task automatic applyStimulus(input logic s_strobe, input logic s_rstc, input logic s_cec,
                                 input logic [AW-1:0] s_a, input logic [AW-1:0] s_b,
                                 input logic [AW-1:0] s_c, input logic sa, input logic sb,
                                 input logic sc, input int zmode, input logic [ZW-1:0] z_val);
        logic [ZW-1:0] ze;
        logic [ZW-1:0] zd;
        ze = golden(s_a, s_b, m_c, sa, sb, sc);
        case (zmode)
            1:       zd = ze ^ (ZW'(1) << $urandom_range(ZW - 1, 0));
            2:       zd = z_val;
            default: zd = ze;
        endcase
        strobe = s_strobe; rstc = s_rstc; cec = s_cec;
        a = s_a; b = s_b; c = s_c;
        a_signed = sa; b_signed = sb; c_signed = sc;
        z_dut = zd;
        if (s_strobe) begin
            if (zd != ze) begin
                if (!m_seen) begin
                    m_fexp = ze; m_fgot = zd; m_fidx = m_idx;
                end
                m_seen = 1'b1;
                if (m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1'b1;
`ifdef DSP_CHK_LAST_ERR_EN
                m_lexp = ze; m_lgot = zd;
`endif
            end
            err_q.push_back('{cnt: m_cnt, seen: m_seen});
            m_idx = m_idx + 1'b1;
            if (s_rstc) m_c = '0;
            else if (s_cec) m_c = s_c;
        end
        @(posedge clk);
        #1;
        strobe = 1'b0; rstc = 1'b0; cec = 1'b0;
    endtask

    task automatic randomStim(input int bad_pct);
        applyStimulus(($urandom_range(99, 0) < 80), ($urandom_range(7, 0) == 0),
                      1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(99, 0) < bad_pct) ? 1 : 0, '0);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        strobe = 1'b0; rstc = 1'b0; cec = 1'b0; rd_req = 1'b0;
        a = '0; b = '0; c = '0; z_dut = '0;
        err_q.delete();
        rec_q.delete();
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_err_count"}, 256'(err_count), 256'(0));
        checkOutput({tag, "_err_seen"}, 256'(err_seen), 256'(0));
        checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
        checkOutput({tag, "_rd_valid"}, 256'(rd_valid), 256'(0));
        checkOutput({tag, "_rd_last"}, 256'(rd_last), 256'(0));
        checkOutput({tag, "_rd_bit"}, 256'(rd_bit), 256'(0));
    endtask

    task automatic doReadout(input logic load_mismatch, input logic abort);
        int n;
        if (!abort) rec_q.push_back(expRecord());
        rd_req = 1'b1;
        if (load_mismatch) begin
            applyStimulus(1'b1, 1'b0, 1'b0, AW'($urandom), AW'($urandom), AW'($urandom),
                          1'b1, 1'b1, 1'b1, 1, '0);
        end else begin
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;
        checkOutput("busy_rise", 256'(busy), 256'(1));
        checkOutput("rd_valid_not_yet", 256'(rd_valid), 256'(0));
        @(posedge clk);
        #1;
        checkOutput("rd_valid_start", 256'(rd_valid), 256'(1));
        if (abort) begin
            repeat (10) begin
                @(posedge clk);
                #1;
            end
            #3;
            resetn = 1'b0;
            #1;
            checkResetState("abort");
            err_q.delete();
            clearModel();
            @(posedge clk);
            #1;
            resetn = 1'b1;
            return;
        end
        for (int i = 0; i < 20; i++) begin
            rd_req = (i == 10);
            randomStim(30);
        end
        rd_req = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("readout_done", 256'(busy), 256'(0));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("idle_after_readout", 256'(rd_valid | busy), 256'(0));
        checkOutput("record_consumed", 256'(rec_q.size()), 256'(0));
    endtask

    // Error-count monitor: compares two edges after each strobe is sampled
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            pend1 <= strobe;
            pend2 <= pend1;
        end
    end

    always @(negedge clk) begin
        err_exp_t e;
        if (resetn && pend2) begin
            if (err_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL err_q_empty got=compare exp=none");
            end else begin
                e = err_q.pop_front();
                checkOutput("err_count", 256'(err_count), 256'(e.cnt));
                checkOutput("err_seen", 256'(err_seen), 256'(e.seen));
            end
        end
    end

    // Readout monitor: gathers rd_bit while rd_valid and compares the whole record on rd_last
    always @(negedge clk) begin
        logic [REC_LEN-1:0] er;
        if (!resetn) begin
            ncol = 0;
        end else if (rd_valid) begin
            col = {col[REC_LEN-2:0], rd_bit};
            ncol++;
            if (rd_last) begin
                checkOutput("rd_last_position", 256'(ncol), 256'(REC_LEN));
                if (rec_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL record_unexpected got=%0h exp=none", col);
                end else begin
                    er = rec_q.pop_front();
                    checkOutput("record", 256'(col), 256'(er));
                end
                ncol = 0;
            end else if (ncol >= REC_LEN) begin
                checks++;
                failures++;
                $display("[TB] FAIL rd_last_missing got=%0d exp=%0d", ncol, REC_LEN);
                ncol = 0;
            end
        end
    end

    initial begin
        clearModel();
        doReset();
        checkResetState("reset");

        // All signed: load C=5, then 3*(2+5)=21 matches
        applyStimulus(1, 0, 1, AW'(0), AW'(0), AW'(5), 1, 1, 1, 0, '0);
        applyStimulus(1, 0, 1, AW'(3), AW'(2), AW'(5), 1, 1, 1, 2, ZW'(21));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("match_21_count", 256'(err_count), 256'(0));

        // Same with z_dut=20: one error, first_idx=1
        doReset();
        applyStimulus(1, 0, 1, AW'(0), AW'(0), AW'(5), 1, 1, 1, 0, '0);
        applyStimulus(1, 0, 1, AW'(3), AW'(2), AW'(5), 1, 1, 1, 2, ZW'(20));
        @(posedge clk);
        #1;
        checkOutput("bad_20_count", 256'(err_count), 256'(1));
        doReadout(1'b0, 1'b0);

        // Three forced mismatches, then readout with a mid-shift rd_req
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, AW'($urandom), AW'($urandom), AW'($urandom), 1, 0, 1, 1, '0);
        end
        repeat (2) @(posedge clk);
        #1;
        doReadout(1'b0, 1'b0);

        // Unsigned extremes: 0x3FFFF * (0x3FFFF + 1)
        doReset();
        applyStimulus(1, 0, 1, AW'(0), AW'(0), AW'(1), 0, 0, 0, 0, '0);
        applyStimulus(1, 0, 0, AW'('h3FFFF), AW'('h3FFFF), AW'(0), 0, 0, 0, 2, ZW'('hFFFFC0000));

        // rstc beats cec; rstc without strobe leaves C alone
        applyStimulus(1, 1, 1, AW'(0), AW'(0), AW'(7), 1, 1, 1, 0, '0);
        applyStimulus(0, 1, 1, AW'(0), AW'(0), AW'(9), 1, 1, 1, 0, '0);
        applyStimulus(1, 0, 0, AW'(1), AW'(0), AW'(0), 1, 1, 1, 2, ZW'(0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstc_clear_count", 256'(err_count), 256'(0));

        for (int i = 0; i < 200; i++) randomStim(25);
        repeat (2) @(posedge clk);
        #1;
        doReadout(1'b1, 1'b0);
        doReadout(1'b0, 1'b0);

        // Saturation of the error counter
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1, 0, 1, AW'($urandom), AW'($urandom), AW'($urandom), 1, 1, 0, 1, '0);
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("saturated_count", 256'(err_count), 256'({CNTW{1'b1}}));
        doReadout(1'b0, 1'b0);

        doReadout(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkResetState("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_preadd_checker.md
Name: dsp_preadd_checker

Overview:
- Consumer-side companion to the pre-adder multiplier hardware-test DUTs with a registered C input and bypassed A, B and output registers.
- Keeps a cycle-accurate golden model of the C register plus the pre-add/multiply path, and compares the DUT's Z on every strobe.
- Counts mismatches, latches the first mismatch, and streams a result record to the host through a serial readout FSM.

Parameters:
- AW, 18, width of A, B and C operands
- ZW, 36, product width (2*AW)
- CNTW, 16, error-counter width; the counter saturates

Ports:
- clk  in  1  single clock, shared with the DUT
- resetn  in  1  asynchronous active-low reset
- strobe  in  1  stimulus-valid qualifier, the same net that gates the DUT's rstc/cec
- a_signed, b_signed, c_signed  in  1 each  operand signedness, as driven to the DUT
- a, b, c  in  AW each  operands, as driven to the DUT
- rstc, cec  in  1 each  C-register reset/enable, pre-strobe gating
- z_dut  in  ZW  DUT output
- rd_req  in  1  single-cycle request to start readout
- rd_bit  out  1  serial data, MSB first
- rd_valid  out  1  high while rd_bit carries a record bit
- rd_last  out  1  high with the final record bit
- err_count  out  CNTW  saturating mismatch count
- err_seen  out  1  sticky: at least one mismatch
- busy  out  1  readout in progress

Behaviour:
- Reset (resetn low, asynchronous):
  - c_model, err_count, captured fields, shift register: 0.
  - err_seen, rd_valid, rd_last, busy, rd_bit: 0.
  - FSM goes to IDLE.
- C model, on each rising edge:
  - if strobe & rstc: c_model <= 0 (reset wins over enable);
  - else if strobe & cec: c_model <= c;
  - else hold.
- Golden model, combinational:
  - Extend b and c_model to AW+2 bits, each by its own flag (sign-extend if flag set, else zero-extend).
  - sum = b_ext + c_ext.
  - Extend a to ZW+2 bits by a_signed; extend sum by (b_signed | c_signed).
  - z_exp = low ZW bits of the product.
- Compare:
  - On a strobe cycle, compare z_dut with z_exp using the c_model value before that edge. This matches the DUT, where C is registered and A/B are combinational.
  - The result is registered: a mismatch affects err_count/err_seen on the edge after the strobe (latency 1).
  - Non-strobe cycles are never compared.
- Mismatch handling:
  - err_count increments and saturates at all-ones.
  - err_seen sets.
  - If this is the first mismatch since reset, first_exp <= z_exp, first_got <= z_dut, first_idx <= strobe index.
  - The strobe index is a CNTW-bit counter of strobe cycles; it wraps.
- Readout FSM, states IDLE -> LOAD -> SHIFT -> IDLE:
  - IDLE: busy=0. rd_req moves to LOAD; rd_req while busy is ignored.
  - LOAD (1 cycle): snapshot the record into the shift register: {err_count, first_idx, first_exp, first_got}, CNTW+CNTW+2*ZW = 104 bits by default. busy=1.
  - SHIFT: one bit per cycle, MSB first, rd_valid=1. rd_last=1 on bit 0, then back to IDLE.
  - The first rd_bit appears 2 cycles after rd_req.
  - Compares keep running during readout; the snapshot is not disturbed.
- Boundary cases:
  - A mismatch in the same cycle as LOAD is not in the snapshot.
  - Counter saturation is permanent until reset.
  - resetn asserted mid-SHIFT aborts immediately; outputs go to their reset values.
  - With no mismatch, the first_* fields read as 0.

Optional Feature:
- Macro: DSP_CHK_LAST_ERR_EN.
- Defined:
  - Also latch last_exp/last_got on every mismatch, overwriting earlier values.
  - The record gains 2*ZW bits appended after first_got: {..., first_got, last_exp, last_got}, 176 bits by default.
- Undefined:
  - No last_* registers; the record is exactly 104 bits.
- rd_last always marks the final bit of whichever record length is compiled.

Decomposition:
- Package dsp_chk_pkg holds:
  - localparams for the record length with and without the feature;
  - the FSM state enum (IDLE, LOAD, SHIFT);
  - a function ext(value, signed_flag, width).
- One sub-module, dsp_preadd_model: c_model register plus combinational z_exp, reusable by the other pre-adder checkers.
- Compare, capture and readout logic stay in the top.

Test Plan:
- All signed. Strobe with cec=1, c=5, then a=3, b=2, z_dut=21 -> no error; err_count=0.
- Same, but z_dut=20 -> one cycle later err_count=1, err_seen=1, first_exp=21, first_got=20, first_idx=1.
- Unsigned a=0x3FFFF, b=0x3FFFF, c_model=1 -> z_exp = 0x3FFFF*0x40000 mod 2^36 = 0xFFFFC0000. A DUT match gives no error.
- rstc=1 and cec=1 with strobe, c=7 -> c_model=0. With strobe=0, rstc=1 -> c_model holds.
- Force 3 mismatches, then pulse rd_req:
  - busy rises next cycle;
  - 104 rd_valid cycles;
  - first 16 bits = 0x0003;
  - rd_last on the final bit;
  - a second rd_req mid-shift is ignored.
- Drop resetn during SHIFT -> rd_valid=0, err_count=0, FSM IDLE immediately. With DSP_CHK_LAST_ERR_EN defined, the same readout is 176 bits and last_got equals the third bad z_dut.
